multi_mode_ff_bank: RTL

- Parametrised bank of WIDTH flip-flop bits sharing one run-time mode register: D, T, SR or JK.
- Generalises the single-bit JK/SR flip-flop blocks:
  - vector width;
  - software-selectable mode;
  - clock enable;
  - a defined policy for the SR s=r=1 condition;
  - illegal-condition detection, with a sticky flag and a saturating event counter.
- Sits wherever control logic needs a bank of state bits with per-bit set/reset/toggle semantics.

---
 rtl/multi_mode_ff_pkg.sv | 21 ++
 rtl/ff_bit_next.sv | 56 +++++
 rtl/multi_mode_ff_bank.sv | 94 +++++++++
 3 files changed

// File: rtl/multi_mode_ff_pkg.sv
`default_nettype none
// ============================================================================
// multi_mode_ff_pkg : mode encodings and s=r=1 policy codes for the FF bank
// Revision 1.0
// ============================================================================
package multi_mode_ff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } mode_e;

  localparam logic [1:0] POL_HOLD   = 2'd0;
  localparam logic [1:0] POL_SET    = 2'd1;
  localparam logic [1:0] POL_RESET  = 2'd2;
  localparam logic [1:0] POL_TOGGLE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ff_bit_next.sv
`default_nettype none
// ============================================================================
// ff_bit_next : next-state and s=r=1 detection for one bit of the FF bank
// Revision 1.0
// ============================================================================
module ff_bit_next
  import multi_mode_ff_pkg::*;
(
  input  mode_e      mode_i,
  input  logic       en_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       q_i,
  input  logic [1:0] policy_i,
  output logic       q_next_o,
  output logic       illegal_o
);

  always_comb begin
    q_next_o  = q_i;
    illegal_o = 1'b0;
    if (en_i) begin
      case (mode_i)
        MODE_D: q_next_o = a_i;
        MODE_T: q_next_o = q_i ^ a_i;
        MODE_SR: begin
          illegal_o = a_i & b_i;
          case ({a_i, b_i})
            2'b10: q_next_o = 1'b1;
            2'b01: q_next_o = 1'b0;
            2'b11: begin
              case (policy_i)
                POL_SET:    q_next_o = 1'b1;
                POL_RESET:  q_next_o = 1'b0;
                POL_TOGGLE: q_next_o = ~q_i;
                default:    q_next_o = q_i;
              endcase
            end
            default: q_next_o = q_i;
          endcase
        end
        MODE_JK: begin
          case ({a_i, b_i})
            2'b10:   q_next_o = 1'b1;
            2'b01:   q_next_o = 1'b0;
            2'b11:   q_next_o = ~q_i;
            default: q_next_o = q_i;
          endcase
        end
        default: q_next_o = q_i;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_mode_ff_bank.sv
`default_nettype none
// ============================================================================
// multi_mode_ff_bank : WIDTH-bit D/T/SR/JK register bank with illegal-event log
// Revision 1.0
// ============================================================================
module multi_mode_ff_bank
  import multi_mode_ff_pkg::*;
#(
  parameter int unsigned WIDTH             = 8,
  parameter int unsigned SR_ILLEGAL_POLICY = 0,
  parameter int unsigned ERR_CNT_W         = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 mode_wr_i,
  input  logic [1:0]           mode_in_i,
  output logic [1:0]           mode_o,
  input  logic                 en_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [WIDTH-1:0]     q_o,
  output logic [WIDTH-1:0]     q_bar_o,
  output logic [WIDTH-1:0]     illegal_mask_o,
  output logic                 illegal_flag_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 err_clr_i
);

  localparam logic [1:0]           POLICY  = 2'(SR_ILLEGAL_POLICY);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  mode_e                mode_q, mode_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     q_bar_q;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic                 flag_q, flag_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0] cnt_base;
  logic                 any_illegal;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      ff_bit_next u_next (
        .mode_i    (mode_q),
        .en_i      (en_i),
        .a_i       (a_i[i]),
        .b_i       (b_i[i]),
        .q_i       (q_q[i]),
        .policy_i  (POLICY),
        .q_next_o  (q_d[i]),
        .illegal_o (mask_d[i])
      );
    end
  endgenerate

  // Clear is applied before the current cycle's event, so clr+event yields 1.
  always_comb begin
    mode_d      = mode_wr_i ? mode_e'(mode_in_i) : mode_q;
    any_illegal = |mask_d;
    cnt_base    = err_clr_i ? '0 : cnt_q;
    cnt_d       = cnt_base;
    if (any_illegal && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + ERR_CNT_W'(1);
    end
    flag_d = any_illegal | (flag_q & ~err_clr_i);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      mode_q  <= MODE_JK;
      q_q     <= '0;
      q_bar_q <= '1;
      mask_q  <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      q_q     <= q_d;
      q_bar_q <= ~q_d;
      mask_q  <= mask_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mode_o         = mode_q;
  assign q_o            = q_q;
  assign q_bar_o        = q_bar_q;
  assign illegal_mask_o = mask_q;
  assign illegal_flag_o = flag_q;
  assign err_cnt_o      = cnt_q;

endmodule
`default_nettype wire
